// File: rtl/fetch_buffered_pkg.sv
// Shared constants for the buffered fetch stage: default widths, PC step
// and the alignment mask used on redirect targets.
package fetch_buffered_pkg;
  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;
  localparam int PC_STEP   = INSTR_LEN / 8;

  // Clears the byte-offset bits below an instruction boundary of `step` bytes.
  function automatic logic [WORD-1:0] align_mask(input int step);
    return ~(WORD'(step) - WORD'(1));
  endfunction
endpackage

// File: rtl/fetch_buffered_if.sv
// Bus bundle of the fetch stage: redirect input, instruction-memory port and
// the valid/ready queue output towards decode.
interface fetch_buffered_if
  import fetch_buffered_pkg::*;
#(
  parameter int ADDR_W  = WORD,
  parameter int INSTR_W = INSTR_LEN,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               pc_src;
  logic [ADDR_W-1:0]  branch_target;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [CNT_W-1:0]   occupancy;

  // Handshake: an entry moves to decode on a cycle where instr_valid and
  // instr_ready are both high; valid never depends on ready, and the head
  // is held stable while ready is low.
  modport master (
    input  pc_src, branch_target, imem_rdata, instr_ready,
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, occupancy
  );
  modport slave (
    output pc_src, branch_target, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, occupancy
  );
endinterface

// File: rtl/fetch_buffered_fifo.sv
// Circular-buffer prefetch queue with wrap-around pointers and a
// synchronous flush that drops every stored entry.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_push = push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= bump(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= bump(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage carries no reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage: PC register, credit-limited sequential memory requests and a
// prefetch queue of {pc, instruction} pairs; pc_src flushes and redirects.
module fetch_buffered
  import fetch_buffered_pkg::*;
#(
  parameter int                ADDR_W   = WORD,
  parameter int                INSTR_W  = INSTR_LEN,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  fetch_buffered_if.master bus
);
  localparam int                STEP       = INSTR_W / 8;
  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(STEP));

  logic [ADDR_W-1:0]         r_pc;
  logic [ADDR_W-1:0]         r_req_pc;
  logic                      r_inflight;
  logic                      w_req;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_valid;
  logic                      w_empty;
  logic [CNT_W-1:0]          w_count;
  logic [CNT_W:0]            w_credit_used;
  logic [ADDR_W+INSTR_W-1:0] w_head;

  // Queued entries plus the outstanding read may never exceed the queue
  // size, so a returning response always has a free slot.
  assign w_credit_used = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
  assign w_req   = !reset && !bus.pc_src && (w_credit_used < (CNT_W+1)'(DEPTH));
  assign w_valid = !w_empty && !bus.pc_src;
  assign w_push  = r_inflight && !bus.pc_src;
  assign w_pop   = w_valid && bus.instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else if (bus.pc_src) begin
      r_pc       <= bus.branch_target & ALIGN_MASK;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc     <= r_pc + ADDR_W'(STEP);
        r_req_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH(ADDR_W + INSTR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (bus.pc_src),
    .din   ({r_req_pc, bus.imem_rdata}),
    .dout  (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.occupancy   = w_count;
  assign bus.instr_pc    = w_empty ? '0 : w_head[ADDR_W+INSTR_W-1 -: ADDR_W];
  assign bus.instruction = w_empty ? '0 : w_head[INSTR_W-1:0];
endmodule
